// File: rtl/conv1d_stream_param_if.sv
// Stream bundle for conv1d_stream_param: filter load, sample load and result
// channels, each a valid/ready pair. The engine uses the slave modport and
// the upstream/downstream environment uses the master modport.
interface conv1d_stream_param_if #(
    parameter int T = 16
);
    logic signed [T-1:0] f_data;
    logic                f_valid;
    logic                f_ready;
    logic signed [T-1:0] x_data;
    logic                x_valid;
    logic                x_ready;
    logic signed [T-1:0] y_data;
    logic                y_valid;
    logic                y_ready;
    logic                y_last;

    modport master (
        output f_data, f_valid, x_data, x_valid, y_ready,
        input  f_ready, x_ready, y_data, y_valid, y_last
    );

    modport slave (
        input  f_data, f_valid, x_data, x_valid, y_ready,
        output f_ready, x_ready, y_data, y_valid, y_last
    );
endinterface

// File: rtl/conv1d_stream_param.sv
// Streaming 1-D valid-mode convolution with a runtime-loadable filter.
// One N-sample frame is buffered, then L = (N-M)/S + 1 outputs are produced,
// each a saturating MAC over M terms (product >>> FRAC, saturate, then
// saturating accumulate in ascending tap order).
// Optional feature: define RELU_EN to clamp negative results to zero.
module conv1d_stream_param #(
    parameter int N    = 32,
    parameter int M    = 10,
    parameter int T    = 16,
    parameter int S    = 1,
    parameter int FRAC = 0
) (
    input logic                  clk,
    input logic                  reset,
    conv1d_stream_param_if.slave bus
);
    localparam int L   = (N - M) / S + 1;
    localparam int XIW = (N > 1) ? $clog2(N) : 1;
    localparam int FIW = (M > 1) ? $clog2(M) : 1;
    localparam int XCW = $clog2(N + 1);
    localparam int JW  = $clog2(M + 1);
    localparam int KW  = $clog2(L + 1);

    localparam logic [XCW-1:0] X_LAST = XCW'(N - 1);
    localparam logic [JW-1:0]  J_LAST = JW'(M - 1);
    localparam logic [JW-1:0]  J_END  = JW'(M);
    localparam logic [KW-1:0]  K_LAST = KW'(L - 1);

    localparam logic signed [T-1:0] SAT_MAX = {1'b0, {(T-1){1'b1}}};
    localparam logic signed [T-1:0] SAT_MIN = {1'b1, {(T-1){1'b0}}};

    typedef enum logic [2:0] {SEL, LOAD_F, LOAD_X, CLR, MAC, OUT} state_t;

    state_t state_reg, state_next;

    logic [JW-1:0]  f_cnt_reg;
    logic [XCW-1:0] x_cnt_reg;
    logic [KW-1:0]  k_reg;
    logic [JW-1:0]  j_issue_reg;
    logic [JW-1:0]  acc_cnt_reg;
    logic           filter_loaded_reg;

    logic signed [T-1:0] f_mem [M];
    logic signed [T-1:0] x_mem [N];

    logic signed [T-1:0] x_rd_reg;
    logic signed [T-1:0] f_rd_reg;
    logic                rd_valid_reg;
    logic signed [T-1:0] prod_reg;
    logic                prod_valid_reg;
    logic signed [T-1:0] acc_reg;
    logic signed [T-1:0] acc_sum;
    logic signed [T-1:0] y_next;
    logic signed [T-1:0] y_data_reg;
    logic                y_last_reg;

    logic           f_ready_c;
    logic           x_ready_c;
    logic           rd_en;
    logic           last_add;
    logic           f_we;
    logic           x_we;
    logic [XIW-1:0] x_rd_addr;
    logic [FIW-1:0] f_rd_addr;

    // Full-width product, arithmetic shift, then clamp to T bits.
    function automatic logic signed [T-1:0] sat_prod(
        input logic signed [T-1:0] a,
        input logic signed [T-1:0] b
    );
        logic signed [2*T-1:0] p;
        p = $signed({{T{a[T-1]}}, a}) * $signed({{T{b[T-1]}}, b});
        p = p >>> FRAC;
        if (p[2*T-1:T-1] == '0 || p[2*T-1:T-1] == '1) begin
            return p[T-1:0];
        end else if (p[2*T-1]) begin
            return SAT_MIN;
        end else begin
            return SAT_MAX;
        end
    endfunction

    // T-bit add with one guard bit, clamped on overflow.
    function automatic logic signed [T-1:0] sat_add(
        input logic signed [T-1:0] a,
        input logic signed [T-1:0] b
    );
        logic signed [T:0] s;
        s = $signed({a[T-1], a}) + $signed({b[T-1], b});
        if (s[T] == s[T-1]) begin
            return s[T-1:0];
        end else if (s[T]) begin
            return SAT_MIN;
        end else begin
            return SAT_MAX;
        end
    endfunction

    // Next-state and handshake decode; readies depend only on the state register.
    always_comb begin
        state_next = state_reg;
        f_ready_c  = 1'b0;
        x_ready_c  = 1'b0;
        rd_en      = 1'b0;
        last_add   = 1'b0;
        case (state_reg)
            SEL: begin
                if (!filter_loaded_reg || bus.f_valid) begin
                    state_next = LOAD_F;
                end else if (bus.x_valid) begin
                    state_next = LOAD_X;
                end
            end
            LOAD_F: begin
                f_ready_c = 1'b1;
                if (bus.f_valid && f_cnt_reg == J_LAST) begin
                    state_next = SEL;
                end
            end
            LOAD_X: begin
                x_ready_c = 1'b1;
                if (bus.x_valid && x_cnt_reg == X_LAST) begin
                    state_next = CLR;
                end
            end
            CLR: begin
                rd_en      = 1'b1;
                state_next = MAC;
            end
            MAC: begin
                rd_en    = (j_issue_reg < J_END);
                last_add = prod_valid_reg && (acc_cnt_reg == J_LAST);
                if (last_add) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                if (bus.y_ready) begin
                    state_next = (k_reg == K_LAST) ? SEL : CLR;
                end
            end
            default: state_next = SEL;
        endcase
    end

    assign f_we = f_ready_c && bus.f_valid;
    assign x_we = x_ready_c && bus.x_valid;

    // Tap j of output k reads x[k*S + j] and f[j].
    assign x_rd_addr = XIW'(k_reg) * XIW'(S) + XIW'(j_issue_reg);
    assign f_rd_addr = FIW'(j_issue_reg);

    // Accumulate step and optional rectification of the finished sum.
    always_comb begin
        acc_sum = sat_add(acc_reg, prod_reg);
`ifdef RELU_EN
        y_next = acc_sum[T-1] ? '0 : acc_sum;
`else
        y_next = acc_sum;
`endif
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= SEL;
        end else begin
            state_reg <= state_next;
        end
    end

    // Load counters and the persistent filter-present flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            f_cnt_reg         <= '0;
            x_cnt_reg         <= '0;
            filter_loaded_reg <= 1'b0;
        end else begin
            if (f_we) begin
                if (f_cnt_reg == J_LAST) begin
                    f_cnt_reg         <= '0;
                    filter_loaded_reg <= 1'b1;
                end else begin
                    f_cnt_reg <= f_cnt_reg + JW'(1);
                end
            end
            if (x_we) begin
                x_cnt_reg <= (x_cnt_reg == X_LAST) ? '0 : x_cnt_reg + XCW'(1);
            end
        end
    end

    // Coefficient and sample buffers: write on accept, registered read.
    always_ff @(posedge clk) begin
        if (f_we) begin
            f_mem[FIW'(f_cnt_reg)] <= bus.f_data;
        end
        if (x_we) begin
            x_mem[XIW'(x_cnt_reg)] <= bus.x_data;
        end
        if (rd_en) begin
            x_rd_reg <= x_mem[x_rd_addr];
            f_rd_reg <= f_mem[f_rd_addr];
        end
    end

    // Product stage: operands arrive one cycle after the read was issued.
    always_ff @(posedge clk) begin
        if (rd_valid_reg) begin
            prod_reg <= sat_prod(x_rd_reg, f_rd_reg);
        end
    end

    // MAC control: tap issue counter, pipeline valids, accumulator, output register.
    always_ff @(posedge clk) begin
        if (reset) begin
            j_issue_reg    <= '0;
            acc_cnt_reg    <= '0;
            rd_valid_reg   <= 1'b0;
            prod_valid_reg <= 1'b0;
            acc_reg        <= '0;
            y_data_reg     <= '0;
            y_last_reg     <= 1'b0;
            k_reg          <= '0;
        end else begin
            rd_valid_reg   <= rd_en;
            prod_valid_reg <= rd_valid_reg;
            if (state_reg != CLR && state_reg != MAC) begin
                j_issue_reg <= '0;
            end else if (rd_en) begin
                j_issue_reg <= j_issue_reg + JW'(1);
            end
            if (state_reg == CLR) begin
                acc_reg     <= '0;
                acc_cnt_reg <= '0;
            end else if (state_reg == MAC && prod_valid_reg) begin
                acc_reg     <= acc_sum;
                acc_cnt_reg <= acc_cnt_reg + JW'(1);
            end
            if (last_add) begin
                y_data_reg <= y_next;
                y_last_reg <= (k_reg == K_LAST);
            end
            if (state_reg == OUT && bus.y_ready) begin
                k_reg <= (k_reg == K_LAST) ? '0 : k_reg + KW'(1);
            end
        end
    end

    assign bus.f_ready = f_ready_c;
    assign bus.x_ready = x_ready_c;
    assign bus.y_valid = (state_reg == OUT);
    assign bus.y_data  = y_data_reg;
    assign bus.y_last  = y_last_reg && (state_reg == OUT);
endmodule

// File: tb/tb_conv1d_stream_param.sv
// Directed bench for conv1d_stream_param: a table of frame scenarios on a
// stride-1 instance and a stride-2/FRAC=1 instance, plus reset sequences.
`timescale 1ns/1ps
module tb_conv1d_stream_param;
    localparam int N = 32;
    localparam int M = 10;
    localparam int T = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic                sel = 1'b0;
    logic signed [T-1:0] f_data = '0;
    logic signed [T-1:0] x_data = '0;
    logic                f_valid = 1'b0;
    logic                x_valid = 1'b0;
    logic                y_ready = 1'b0;
    logic                f_ready_m, x_ready_m, y_valid_m, y_last_m;
    logic signed [T-1:0] y_data_m;

    conv1d_stream_param_if #(.T(T)) ifa ();
    conv1d_stream_param_if #(.T(T)) ifb ();

    assign ifa.f_data  = f_data;
    assign ifa.x_data  = x_data;
    assign ifa.f_valid = f_valid & ~sel;
    assign ifa.x_valid = x_valid & ~sel;
    assign ifa.y_ready = y_ready & ~sel;
    assign ifb.f_data  = f_data;
    assign ifb.x_data  = x_data;
    assign ifb.f_valid = f_valid & sel;
    assign ifb.x_valid = x_valid & sel;
    assign ifb.y_ready = y_ready & sel;

    assign f_ready_m = sel ? ifb.f_ready : ifa.f_ready;
    assign x_ready_m = sel ? ifb.x_ready : ifa.x_ready;
    assign y_valid_m = sel ? ifb.y_valid : ifa.y_valid;
    assign y_last_m  = sel ? ifb.y_last  : ifa.y_last;
    assign y_data_m  = sel ? ifb.y_data  : ifa.y_data;

    conv1d_stream_param #(.N(N), .M(M), .T(T), .S(1), .FRAC(0)) dut (
        .clk(clk), .reset(reset), .bus(ifa)
    );
    conv1d_stream_param #(.N(N), .M(M), .T(T), .S(2), .FRAC(1)) dut2 (
        .clk(clk), .reset(reset), .bus(ifb)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int f_done_cyc = 0;
    int x_first_cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int sel;      // 0: S=1/FRAC=0 instance, 1: S=2/FRAC=1 instance
        int load;     // send a filter before the frame
        int f_kind;   // 0 identity, 1 last tap, 2 all 32767, 3 all -1, 4 [2,0..]
        int x_kind;   // 0 ramp 0..31, 1 all 32767, 2 all 100
        int stall;    // y_ready pattern 1,0,0 when set
        int exp_n;    // beats per frame
        int exp_base; // y[k] = exp_base + exp_step*k
        int exp_step;
    } vec_t;

    localparam int NV = 7;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic signed [T-1:0] coef(input int kind, input int i);
        logic signed [T-1:0] r;
        r = '0;
        case (kind)
            0: r = (i == 0) ? T'(1) : T'(0);
            1: r = (i == M - 1) ? T'(1) : T'(0);
            2: r = T'(32767);
            3: r = T'(-1);
            4: r = (i == 0) ? T'(2) : T'(0);
            default: r = '0;
        endcase
        return r;
    endfunction

    function automatic logic signed [T-1:0] samp(input int kind, input int i);
        logic signed [T-1:0] r;
        r = '0;
        case (kind)
            0: r = T'(i);
            1: r = T'(32767);
            2: r = T'(100);
            default: r = '0;
        endcase
        return r;
    endfunction

    task automatic drive_f(input int kind);
        logic hs;
        int guard;
        for (int i = 0; i < M; i++) begin
            f_data  = coef(kind, i);
            f_valid = 1'b1;
            hs      = 1'b0;
            guard   = 0;
            while (!hs) begin
                @(negedge clk);
                hs = f_ready_m;
                @(posedge clk);
                #1;
                guard++;
                if (!hs && guard > 1000) begin
                    check("f_timeout", i, M);
                    f_valid = 1'b0;
                    return;
                end
            end
            if (i == M - 1) f_done_cyc = cyc;
        end
        f_valid = 1'b0;
    endtask

    task automatic drive_x(input int kind);
        logic hs;
        int guard;
        for (int i = 0; i < N; i++) begin
            x_data  = samp(kind, i);
            x_valid = 1'b1;
            hs      = 1'b0;
            guard   = 0;
            while (!hs) begin
                @(negedge clk);
                hs = x_ready_m;
                @(posedge clk);
                #1;
                guard++;
                if (!hs && guard > 1000) begin
                    check("x_timeout", i, N);
                    x_valid = 1'b0;
                    return;
                end
            end
            if (i == 0) x_first_cyc = cyc;
        end
        x_valid = 1'b0;
    endtask

    // Accept n beats; every valid cycle (stalled or not) is compared to the
    // value the current beat must carry, so holds, losses and repeats show up.
    task automatic collect(input int n, input int last_idx, input int base,
                           input int step, input int stall);
        int beat;
        int waitc;
        logic rdy;
        beat  = 0;
        waitc = 0;
        while (beat < n && waitc < 3000) begin
            rdy     = (stall == 0) || (waitc % 3 == 0);
            y_ready = rdy;
            @(negedge clk);
            if (y_valid_m) begin
                if (rdy) begin
                    check("y_data", int'(y_data_m), base + step * beat);
                    check("y_last", int'(y_last_m), int'(beat == last_idx));
                    beat++;
                end else begin
                    check("stall_data", int'(y_data_m), base + step * beat);
                    check("stall_last", int'(y_last_m), int'(beat == last_idx));
                end
            end
            @(posedge clk);
            #1;
            waitc++;
        end
        y_ready = 1'b0;
        if (beat < n) check("y_timeout", beat, n);
    endtask

    initial begin
        logic f_seen;

        vecs[0] = '{0, 1, 0, 0, 0, 23, 0, 1};
        vecs[1] = '{0, 1, 2, 1, 0, 23, 32767, 0};
`ifdef RELU_EN
        vecs[2] = '{0, 1, 3, 2, 0, 23, 0, 0};
`else
        vecs[2] = '{0, 1, 3, 2, 0, 23, -1000, 0};
`endif
        vecs[3] = '{0, 1, 0, 0, 1, 23, 0, 1};
        vecs[4] = '{0, 0, 0, 0, 0, 23, 0, 1};
        vecs[5] = '{0, 1, 1, 0, 0, 23, 9, 1};
        vecs[6] = '{1, 1, 4, 0, 0, 12, 0, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("rst_f_ready", int'(f_ready_m), 0);
        check("rst_x_ready", int'(x_ready_m), 0);
        check("rst_y_valid", int'(y_valid_m), 0);
        check("rst_y_last", int'(y_last_m), 0);
        check("rst_y_data", int'(y_data_m), 0);
        @(posedge clk);
        #1;

        for (int v = 0; v < NV; v++) begin
            sel         = vecs[v].sel[0];
            f_done_cyc  = 0;
            x_first_cyc = 0;
            fork
                begin
                    if (vecs[v].load != 0) drive_f(vecs[v].f_kind);
                end
                drive_x(vecs[v].x_kind);
                collect(vecs[v].exp_n, vecs[v].exp_n - 1, vecs[v].exp_base,
                        vecs[v].exp_step, vecs[v].stall);
            join
            if (vecs[v].load != 0) begin
                check("filter_first", int'(x_first_cyc > f_done_cyc), 1);
            end
            @(negedge clk);
            check("no_extra_beat", int'(y_valid_m), 0);
            @(posedge clk);
            #1;
            $display("frame %0d: sel=%0d load=%0d f=%0d x=%0d stall=%0d beats=%0d total=%0d bad=%0d",
                     v, vecs[v].sel, vecs[v].load, vecs[v].f_kind, vecs[v].x_kind,
                     vecs[v].stall, vecs[v].exp_n, total, bad);
        end

        // Reset one cycle after the 5th output handshake
        sel = 1'b0;
        fork
            drive_f(0);
            drive_x(0);
            collect(5, -1, 0, 1, 0);
        join
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_y_valid", int'(y_valid_m), 0);
        check("mid_rst_x_ready", int'(x_ready_m), 0);
        check("mid_rst_f_ready", int'(f_ready_m), 0);
        check("mid_rst_y_data", int'(y_data_m), 0);
        @(posedge clk);
        #1;
        x_valid = 1'b1;
        x_data  = T'(7);
        f_seen  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("post_rst_no_x", int'(x_ready_m), 0);
            check("post_rst_no_y", int'(y_valid_m), 0);
            f_seen = f_seen | f_ready_m;
            @(posedge clk);
            #1;
        end
        x_valid = 1'b0;
        check("post_rst_f_ready", int'(f_seen), 1);
        $display("reset sequence: total=%0d bad=%0d", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
